data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Next-generation data memory for the 5-stage pipeline's MEM stage. Word array of
//  parametrised depth with RV32 byte/half/word loads and stores, sign/zero extension,
//  and a registered read with valid/ready handshake. Flags misaligned, illegal and
//  out-of-range accesses. Optionally zeroes the array after reset with an internal sweep.
// PARAMETERS
//  DEPTH           65536  number of 32-bit words; power of two, >= 4
//  CLEAR_ON_RESET  1      1: zero every word after reset (DEPTH cycles); 0: contents kept
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present this cycle
//  req_ready  out  1   block can accept a request (IDLE state)
//  MemWrite   in   1   1 = store, 0 = load
//  funct3     in   3   RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  A          in   32  byte address
//  WD         in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1   one-cycle pulse: response for the request accepted last cycle
//  RD         out  32  load result, extended per funct3; 0 for stores and faults
//  fault      out  1   valid with rsp_valid: access rejected
//  busy       out  1   clear sweep in progress
// BEHAVIOUR
//  - Accept = req_valid & req_ready. Every accepted request, store or load, gets exactly
//    one response: rsp_valid=1 on the next cycle. Latency is 1 and throughput is 1/cycle.
//  - Reset, synchronous: rsp_valid=0, RD=0, fault=0, sweep counter=0.
//    CLEAR_ON_RESET=1: state goes to INIT; busy=1, req_ready=0.
//    CLEAR_ON_RESET=0: state goes to IDLE; busy=0, req_ready=1 from the first cycle after reset.
//  - FSM INIT: each cycle writes word[cnt]=0 and then increments cnt. When cnt==DEPTH-1
//    is written, the next state is IDLE. INIT lasts exactly DEPTH cycles after reset
//    deasserts. Reset asserted during INIT restarts the sweep at cnt=0.
//  - FSM IDLE: req_ready=1 and busy=0. The FSM stays in IDLE until reset.
//  - Word index = A[31:2], lane = A[1:0]. The access faults if any of these hold:
//      funct3 is 011, 110 or 111, or funct3=110/111 on a store;
//      H/HU with A[0]=1;
//      W with A[1:0]!=0;
//      BU/HU on a store;
//      A[31:2] >= DEPTH.
//    A faulted access writes nothing; its response has fault=1 and RD=0.
//  - Store, committed at the accept edge:
//      SB writes byte lane A[1:0] with WD[7:0];
//      SH writes lanes {A[1],1} and {A[1],0} with WD[15:0];
//      SW writes all four lanes with WD.
//    Lanes that are not written keep their value.
//  - Load: the word is read at the accept edge, then the lane is selected and extended.
//      LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
//    A load accepted the cycle after a store to the same word returns the stored data.
//  - Between pulses, rsp_valid=0; RD and fault hold their last values. Requests while
//    req_ready=0 are ignored; no response and no write.
//  - Outputs are only valid as described above; there are no X on any output after reset.
// TESTING  (DEPTH=16 unless noted)
//  1. CLEAR_ON_RESET=1; reset 2 cycles -> busy=1 for 16 cycles, then req_ready=1;
//     LW of 0x00..0x3C -> RD=0, fault=0, one rsp_valid per request.
//  2. SW 0x8=0xDEADBEEF, then next-cycle loads at 0x8/0xB/0xB/0xA/0x8
//     (LW/LB/LBU/LH/LHU) -> 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF.
//  3. From test 2 state: SB 0x9 WD=0xAB12 -> LW 0x8 = 0xDEAD12EF;
//     then SH 0xA WD=0x5678 -> LW 0x8 = 0x567812EF.
//  4. Faults:
//     - LW 0x6 -> fault=1, RD=0;
//     - SW 0x2 WD=0xFFFFFFFF -> fault=1, then LW 0x0 is unchanged;
//     - LH 0x1 -> fault;
//     - funct3=011 -> fault;
//     - SW 0x40 -> fault, then LW 0x0 is unchanged (no aliasing).
//  5. Back-to-back, req_valid held high for 8 cycles of mixed SW/LW -> 8 consecutive
//     rsp_valid pulses, 1 cycle after each accept, with correct data.
//  6. Reset asserted at INIT cycle 5 -> busy stays 1 for 16 more cycles after reset
//     drops. With CLEAR_ON_RESET=0: SW 0x4=0x1234, then reset, then LW 0x4 = 0x00001234.

Source files
------------

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: RV32 byte/half/word load-store unit over a DEPTH-word array, optional zeroing sweep after reset.
// Latency: one cycle from accept to rsp_valid for loads, stores and faulted accesses; one request per cycle.
// Backpressure: req_ready is low only while the clear sweep runs; responses never stall, rsp_valid is a pulse.
module data_memory_lsu #(
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        rsp_valid,
    output logic [31:0] RD,
    output logic        fault,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          is_b;
    logic          is_h;
    logic          is_w;
    logic          is_u;
    logic          bad_f3;
    logic          misaligned;
    logic          oor;
    logic          acc_fault;
    logic          do_store;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Request decode: fault classification, store lane enables and load extraction.
    always_comb begin
        accept     = req_valid & req_ready & ~reset;
        is_b       = (funct3[1:0] == 2'b00);
        is_h       = (funct3[1:0] == 2'b01);
        is_w       = (funct3 == 3'b010);
        is_u       = funct3[2];
        bad_f3     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        misaligned = (is_h & A[0]) | (is_w & (|A[1:0]));
        // Compare the full word index so addresses past the array never alias onto it.
        oor        = ({2'b00, A[31:2]} >= 32'(DEPTH));
        acc_fault  = bad_f3 | misaligned | (MemWrite & is_u) | oor;
        widx       = A[AW+1:2];
        do_store   = accept & MemWrite & ~acc_fault;

        be    = 4'b1111;
        wdata = WD;
        if (is_b) begin
            be    = 4'b0001 << A[1:0];
            wdata = {4{WD[7:0]}};
        end else if (is_h) begin
            be    = A[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WD[15:0]}};
        end

        word    = mem[widx];
        ld_byte = word[{A[1:0], 3'b000} +: 8];
        ld_half = A[1] ? word[31:16] : word[15:0];
        if (is_w) begin
            ld_data = word;
        end else if (is_b) begin
            ld_data = {{24{~is_u & ld_byte[7]}}, ld_byte};
        end else begin
            ld_data = {{16{~is_u & ld_half[15]}}, ld_half};
        end
    end

    // Control FSM: clear sweep after reset, then permanent IDLE with registered ready/busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            if (CLEAR_ON_RESET) begin
                state     <= S_INIT;
                busy      <= 1'b1;
                req_ready <= 1'b0;
            end else begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                req_ready <= 1'b1;
            end
        end else if (state == S_INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                req_ready <= 1'b1;
            end
        end
    end

    // Array write port: sweep zeroes one word per cycle, otherwise committed stores update their lanes.
    always_ff @(posedge clk) begin
        if (state == S_INIT && !reset) begin
            mem[cnt] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response register: one pulse per accept; RD and fault hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            RD        <= '0;
            fault     <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                fault <= acc_fault;
                RD    <= (acc_fault | MemWrite) ? 32'd0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: scoreboarded bench for data_memory_lsu with a byte-array reference model.
// Latency: responses are expected one cycle after each accepted request.
// Backpressure: requests are only issued once the clear sweep has finished.
module tb_data_memory_lsu;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with clear-on-reset
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b010;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic        rsp_valid;
    logic [31:0] RD;
    logic        fault;
    logic        busy;

    // Instance that keeps contents over reset
    logic        reset0 = 1'b1;
    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic        MemWrite0 = 1'b0;
    logic [2:0]  funct30 = 3'b010;
    logic [31:0] A0 = '0;
    logic [31:0] WD0 = '0;
    logic        rsp_valid0;
    logic [31:0] RD0;
    logic        fault0;
    logic        busy0;

    data_memory_lsu #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemWrite(MemWrite), .funct3(funct3), .A(A), .WD(WD),
        .rsp_valid(rsp_valid), .RD(RD), .fault(fault), .busy(busy)
    );

    data_memory_lsu #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut_keep (
        .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
        .MemWrite(MemWrite0), .funct3(funct30), .A(A0), .WD(WD0),
        .rsp_valid(rsp_valid0), .RD(RD0), .fault(fault0), .busy(busy0)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t q0[$];
    logic [7:0] mm [0:4*DEPTH-1];

    // Reference model: byte-addressed little-endian memory and the access rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic flt);
        int          size;
        logic        sgn;
        logic [31:0] v;
        flt  = 1'b0;
        sgn  = 1'b0;
        size = 4;
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: flt = 1'b1;
        endcase
        if ((a % size) != 0) flt = 1'b1;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) flt = 1'b1;
        if ((a >> 2) >= DEPTH) flt = 1'b1;
        rd = '0;
        if (!flt) begin
            if (we) begin
                for (int k = 0; k < size; k++) mm[a + k] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < size; k++) v = v | (32'(mm[a + k]) << (8 * k));
                if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        MemWrite  = we;
        funct3    = f3;
        A         = a;
        WD        = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        model(we, f3, a, wd, e.rd, e.flt);
        q.push_back(e);
        drive(we, f3, a, wd);
    endtask

    // Directed request whose response is a fixed expected value; the model still tracks stores.
    task automatic issue_k(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_f);
        exp_t e;
        exp_t k;
        model(we, f3, a, wd, e.rd, e.flt);
        k.rd  = exp_rd;
        k.flt = exp_f;
        q.push_back(k);
        drive(we, f3, a, wd);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s_ready_low: req_ready=%b while busy, need 0", tag, req_ready);
            end
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL %s_busy_len: busy cycles=%0d, need %0d", tag, n, DEPTH);
        end
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: req_ready=%b busy=%b, need 1/0", tag, req_ready, busy);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor for the clearing instance: reset values, latency, scoreboard pops and hold behaviour.
    logic        started = 1'b0;
    logic        rst_prev = 1'b0;
    logic        acc_prev = 1'b0;
    logic [31:0] last_rd = '0;
    logic        last_f = 1'b0;
    exp_t        me;
    always @(negedge clk) begin
        if (started) begin
            if (rst_prev) begin
                total++;
                if (rsp_valid !== 1'b0 || RD !== 32'd0 || fault !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_outputs: rsp_valid=%b RD=%h fault=%b, need 0/0/0", rsp_valid, RD, fault);
                end
                last_rd = '0;
                last_f  = 1'b0;
            end else begin
                if (acc_prev || rsp_valid !== 1'b0) begin
                    total++;
                    if (rsp_valid !== acc_prev) begin
                        bad++;
                        $display("FAIL rsp_timing: rsp_valid=%b, need %b", rsp_valid, acc_prev);
                    end
                end
                if (rsp_valid === 1'b1) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL rsp_unexpected: RD=%h fault=%b with no request outstanding", RD, fault);
                    end else begin
                        me = q.pop_front();
                        if (RD !== me.rd || fault !== me.flt) begin
                            bad++;
                            $display("FAIL rsp_data: RD=%h fault=%b, need RD=%h fault=%b", RD, fault, me.rd, me.flt);
                        end
                        last_rd = me.rd;
                        last_f  = me.flt;
                    end
                end else if (rsp_valid === 1'b0) begin
                    total++;
                    if (RD !== last_rd || fault !== last_f) begin
                        bad++;
                        $display("FAIL rsp_hold: RD=%h fault=%b, need RD=%h fault=%b", RD, fault, last_rd, last_f);
                    end
                end
            end
        end
        rst_prev = reset;
        acc_prev = req_valid && (req_ready === 1'b1) && !reset;
        if (reset) started = 1'b1;
    end

    // Monitor for the contents-keeping instance.
    exp_t me0;
    always @(negedge clk) begin
        if (rsp_valid0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL keep_unexpected: RD=%h fault=%b with no request outstanding", RD0, fault0);
            end else begin
                me0 = q0.pop_front();
                if (RD0 !== me0.rd || fault0 !== me0.flt) begin
                    bad++;
                    $display("FAIL keep_data: RD=%h fault=%b, need RD=%h fault=%b", RD0, fault0, me0.rd, me0.flt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t     e0;
        logic     we;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 8'h00;

        // Clear sweep length and then loads of every word read zero
        #1;
        do_reset(2);
        count_busy("init");
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 3'b010, 32'(4 * i), 32'd0);
        idle(1);

        // Store then extended loads in the following cycles
        issue_k(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
        issue_k(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);
        issue_k(1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue_k(1'b0, 3'b100, 32'hB, 32'h0, 32'h000000DE, 1'b0);
        issue_k(1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue_k(1'b0, 3'b101, 32'h8, 32'h0, 32'h0000BEEF, 1'b0);
        idle(1);

        // Partial stores keep untouched lanes
        issue_k(1'b1, 3'b000, 32'h9, 32'h0000AB12, 32'h0, 1'b0);
        issue_k(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD12EF, 1'b0);
        issue_k(1'b1, 3'b001, 32'hA, 32'h00005678, 32'h0, 1'b0);
        issue_k(1'b0, 3'b010, 32'h8, 32'h0, 32'h567812EF, 1'b0);
        idle(2);

        // Fault cases
        issue_k(1'b1, 3'b010, 32'h0, 32'h11223344, 32'h0, 1'b0);
        issue_k(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1);
        issue_k(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue_k(1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0);
        issue_k(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1);
        issue_k(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        issue_k(1'b1, 3'b100, 32'h4, 32'h55, 32'h0, 1'b1);
        issue_k(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1);
        issue_k(1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0);
        idle(1);

        // Back-to-back store/load pairs, one accept per cycle
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(DEPTH - 1)) << 2;
            issue(1'b1, 3'b010, a, $urandom);
            issue(1'b0, 3'b010, a, 32'd0);
        end
        idle(1);

        // Randomized mix including bad codes, misalignment and out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                idle(1);
            end else begin
                we = 1'($urandom_range(1));
                f3 = 3'($urandom_range(7));
                if ($urandom_range(9) == 0) a = $urandom;
                else a = 32'($urandom_range(4 * DEPTH - 1));
                issue(we, f3, a, $urandom);
            end
        end
        idle(2);

        // Reset in the middle of the sweep restarts it; requests during the sweep are ignored
        do_reset(2);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        fork
            count_busy("restart");
            begin
                repeat (3) @(posedge clk);
                #1;
                req_valid = 1'b1;
                MemWrite  = 1'b1;
                funct3    = 3'b010;
                A         = 32'h0;
                WD        = 32'hFFFFFFFF;
                repeat (7) @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        join
        for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 3'b010, 32'(4 * i), 32'd0);
        idle(3);

        // Contents survive reset when clearing is disabled
        reset0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset0 = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready0 !== 1'b1 || busy0 !== 1'b0 || rsp_valid0 !== 1'b0 || RD0 !== 32'd0) begin
            bad++;
            $display("FAIL keep_reset: ready=%b busy=%b rsp_valid=%b RD=%h, need 1/0/0/0",
                     req_ready0, busy0, rsp_valid0, RD0);
        end
        @(posedge clk);
        #1;
        e0.rd = 32'h0; e0.flt = 1'b0; q0.push_back(e0);
        req_valid0 = 1'b1; MemWrite0 = 1'b1; funct30 = 3'b010; A0 = 32'h4; WD0 = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset0 = 1'b0;
        e0.rd = 32'h00001234; e0.flt = 1'b0; q0.push_back(e0);
        req_valid0 = 1'b1; MemWrite0 = 1'b0; funct30 = 3'b010; A0 = 32'h4; WD0 = 32'h0;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        total++;
        if (q.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding=%0d/%0d responses never seen, need 0/0", q.size(), q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
